mem_bus_ctrl: RTL and testbench

- Memory-side bus controller directly downstream of the core's data/instruction bus.
- Decodes core addresses into a RAM window and a machine-timer register window.
- Performs byte-lane steering for sub-word stores and right-aligns load data; the core does the sign or zero extension.
- Owns the 64-bit mtime/mtimecmp machine timer, raises timer_irq toward the core, and flags misaligned or unmapped accesses.

---
 rtl/mem_bus_ctrl_if.sv | 19 +
 rtl/mem_bus_ctrl.sv | 133 +++++++++++++
 tb/tb_mem_bus_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// Core-side data/instruction bus between the core and the memory bus controller.
interface mem_bus_ctrl_if;
   logic [31:0] core_addr;
   logic [31:0] core_wdata;
   logic [31:0] core_rdata;
   logic        core_read_en;
   logic        core_write_en;
   logic [1:0]  core_width;

   modport master (
      output core_addr, core_wdata, core_read_en, core_write_en, core_width,
      input  core_rdata
   );

   modport slave (
      input  core_addr, core_wdata, core_read_en, core_write_en, core_width,
      output core_rdata
   );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory-side bus controller: RAM/timer decode, store lane steering, load
// right-alignment, 64-bit machine timer with interrupt, and fault reporting.
module mem_bus_ctrl #(
   parameter int          RAM_ADDR_W = 14,
   parameter logic [31:0] TIMER_BASE = 32'hFFFF_0000,
   parameter int          TICK_DIV   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   mem_bus_ctrl_if.slave         bus,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic [31:0]           ram_wdata,
   output logic [3:0]            ram_byte_en,
   output logic                  ram_we,
   input  logic [31:0]           ram_rdata,
   output logic                  timer_irq,
   output logic                  bus_fault,
   output logic [31:0]           fault_addr
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   mtimecmp_q, mtimecmp_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          irq_q, irq_d;
   logic          fault_q, fault_d;
   logic [31:0]   fault_addr_q, fault_addr_d;

   logic [31:0] addr;
   logic        access, ram_hit, timer_hit, fault, tick, timer_we;
   logic [31:0] rdata;

   assign addr      = bus.core_addr;
   assign access    = bus.core_read_en | bus.core_write_en;
   // Shift form avoids overflowing 32 bits when the RAM spans the whole space.
   assign ram_hit   = (addr >> (RAM_ADDR_W + 2)) == 32'd0;
   assign timer_hit = addr[31:4] == TIMER_BASE[31:4];
   assign tick      = presc_q == PW'(TICK_DIV - 1);
   assign ram_addr  = addr[RAM_ADDR_W+1:2];

   // Fault detection: bad width, misalignment, sub-word timer access, unmapped.
   always_comb begin
      fault = 1'b0;
      if (access) begin
         if (bus.core_width == 2'd3)                             fault = 1'b1;
         if (bus.core_width == 2'd1 && addr[0])                  fault = 1'b1;
         if (bus.core_width == 2'd2 && addr[1:0] != 2'b00)       fault = 1'b1;
         if (timer_hit && bus.core_width != 2'd2)                fault = 1'b1;
         if (!ram_hit && !timer_hit)                             fault = 1'b1;
      end
   end

   // Store lane steering and the RAM write strobe.
   always_comb begin
      ram_wdata   = bus.core_wdata;
      ram_byte_en = 4'b1111;
      case (bus.core_width)
         2'd0: begin
            ram_wdata   = {4{bus.core_wdata[7:0]}};
            ram_byte_en = 4'b0001 << addr[1:0];
         end
         2'd1: begin
            ram_wdata   = {2{bus.core_wdata[15:0]}};
            ram_byte_en = addr[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
      ram_we = bus.core_write_en & ram_hit & ~fault & ~reset;
   end

   // Load path: right-aligned RAM word or current timer register, zero otherwise.
   always_comb begin
      rdata = 32'd0;
      if (access && !fault) begin
         if (ram_hit) begin
            rdata = ram_rdata >> {addr[1:0], 3'b000};
         end else if (timer_hit) begin
            case (addr[3:2])
               2'd0:    rdata = mtime_q[31:0];
               2'd1:    rdata = mtime_q[63:32];
               2'd2:    rdata = mtimecmp_q[31:0];
               default: rdata = mtimecmp_q[63:32];
            endcase
         end
      end
   end
   assign bus.core_rdata = rdata;

   assign timer_we = bus.core_write_en & timer_hit & ~fault;

   // Timer next state: prescaled increment, bus writes override the increment.
   always_comb begin
      presc_d    = tick ? '0 : presc_q + PW'(1);
      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d = mtimecmp_q;
      if (timer_we) begin
         case (addr[3:2])
            2'd0:    mtime_d         = {mtime_q[63:32], bus.core_wdata};
            2'd1:    mtime_d         = {bus.core_wdata, mtime_q[31:0]};
            2'd2:    mtimecmp_d[31:0]  = bus.core_wdata;
            default: mtimecmp_d[63:32] = bus.core_wdata;
         endcase
      end
      irq_d        = mtime_d >= mtimecmp_d;
      fault_d      = fault;
      fault_addr_d = fault ? addr : fault_addr_q;
   end

   // State registers; reset also discards the prescaler phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         mtime_q      <= 64'd0;
         mtimecmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
         presc_q      <= '0;
         irq_q        <= 1'b0;
         fault_q      <= 1'b0;
         fault_addr_q <= 32'd0;
      end else begin
         mtime_q      <= mtime_d;
         mtimecmp_q   <= mtimecmp_d;
         presc_q      <= presc_d;
         irq_q        <= irq_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
      end
   end

   assign timer_irq  = irq_q;
   assign bus_fault  = fault_q;
   assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: one instance with TICK_DIV=1, one with TICK_DIV=4.
module tb_mem_bus_ctrl;
   localparam logic [31:0] TB = 32'hFFFF_0000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_bus_ctrl_if bus1 ();
   mem_bus_ctrl_if bus4 ();

   logic [13:0] ram_addr1, ram_addr4;
   logic [31:0] ram_wdata1, ram_wdata4, ram_rdata1, ram_rdata4;
   logic [3:0]  ram_be1, ram_be4;
   logic        ram_we1, ram_we4, irq1, irq4, flt1, flt4;
   logic [31:0] faddr1, faddr4;

   mem_bus_ctrl #(.RAM_ADDR_W(14), .TIMER_BASE(TB), .TICK_DIV(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave),
      .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_byte_en(ram_be1),
      .ram_we(ram_we1), .ram_rdata(ram_rdata1), .timer_irq(irq1),
      .bus_fault(flt1), .fault_addr(faddr1)
   );

   mem_bus_ctrl #(.RAM_ADDR_W(14), .TIMER_BASE(TB), .TICK_DIV(4)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4.slave),
      .ram_addr(ram_addr4), .ram_wdata(ram_wdata4), .ram_byte_en(ram_be4),
      .ram_we(ram_we4), .ram_rdata(ram_rdata4), .timer_irq(irq4),
      .bus_fault(flt4), .fault_addr(faddr4)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // Edges seen since reset release; gives the TICK_DIV=4 prescaler phase.
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set1(input logic rd, input logic wr, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] d);
      bus1.core_read_en  = rd;
      bus1.core_write_en = wr;
      bus1.core_width    = w;
      bus1.core_addr     = a;
      bus1.core_wdata    = d;
      #1;
   endtask

   task automatic set4(input logic rd, input logic wr, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] d);
      bus4.core_read_en  = rd;
      bus4.core_write_en = wr;
      bus4.core_width    = w;
      bus4.core_addr     = a;
      bus4.core_wdata    = d;
      #1;
   endtask

   int exp_t;
   int guard;

   initial begin
      reset = 1'b1;
      ram_rdata1 = 32'd0;
      ram_rdata4 = 32'd0;
      set4(1'b0, 1'b0, 2'd2, 32'd0, 32'd0);
      // A store presented during reset must not reach the RAM.
      set1(1'b0, 1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF);
      chk("rst_ram_we", {63'd0, ram_we1}, 64'd0);
      repeat (3) step();
      reset = 1'b0;
      set1(1'b0, 1'b0, 2'd2, 32'd0, 32'd0);
      chk("rst_irq", {63'd0, irq1}, 64'd0);
      chk("rst_fault", {63'd0, flt1}, 64'd0);
      chk("rst_faddr", {32'd0, faddr1}, 64'd0);

      // Five idle cycles at TICK_DIV=1.
      repeat (5) step();
      set1(1'b1, 1'b0, 2'd2, TB + 32'h0, 32'd0);
      chk("mtime_lo_5", {32'd0, bus1.core_rdata}, 64'd5);
      set1(1'b1, 1'b0, 2'd2, TB + 32'h4, 32'd0);
      chk("mtime_hi_5", {32'd0, bus1.core_rdata}, 64'd0);
      chk("irq_idle", {63'd0, irq1}, 64'd0);
      chk("fault_idle", {63'd0, flt1}, 64'd0);

      // Byte and half store steering.
      set1(1'b0, 1'b1, 2'd0, 32'h0000_0102, 32'h0000_00A5);
      chk("sb_be", {60'd0, ram_be1}, 64'h4);
      chk("sb_wdata", {32'd0, ram_wdata1}, 64'hA5A5_A5A5);
      chk("sb_we", {63'd0, ram_we1}, 64'd1);
      chk("sb_addr", {50'd0, ram_addr1}, 64'h40);
      step();
      set1(1'b0, 1'b1, 2'd1, 32'h0000_0002, 32'h0000_BEEF);
      chk("sh_be", {60'd0, ram_be1}, 64'hC);
      chk("sh_wdata", {32'd0, ram_wdata1}, 64'hBEEF_BEEF);
      step();
      ram_rdata1 = 32'h12A5_3456;
      set1(1'b1, 1'b0, 2'd1, 32'h0000_0102, 32'd0);
      chk("lh_rdata", {32'd0, bus1.core_rdata}, 64'h0000_12A5);
      chk("lh_we", {63'd0, ram_we1}, 64'd0);
      set1(1'b0, 1'b0, 2'd2, 32'h0000_0102, 32'd0);
      chk("idle_rdata", {32'd0, bus1.core_rdata}, 64'd0);
      step();

      // Misaligned word load.
      set1(1'b1, 1'b0, 2'd2, 32'h0000_0006, 32'd0);
      chk("mis_rdata", {32'd0, bus1.core_rdata}, 64'd0);
      chk("mis_we", {63'd0, ram_we1}, 64'd0);
      chk("mis_nofault_yet", {63'd0, flt1}, 64'd0);
      step();
      set1(1'b0, 1'b0, 2'd2, 32'd0, 32'd0);
      chk("mis_fault", {63'd0, flt1}, 64'd1);
      chk("mis_faddr", {32'd0, faddr1}, 64'h6);
      step();
      chk("mis_fault_clr", {63'd0, flt1}, 64'd0);
      chk("mis_faddr_hold", {32'd0, faddr1}, 64'h6);

      // Back-to-back faults: reserved width, two cycles.
      set1(1'b1, 1'b0, 2'd3, 32'h0000_0020, 32'd0);
      step();
      chk("b2b_fault1", {63'd0, flt1}, 64'd1);
      set1(1'b0, 1'b1, 2'd3, 32'h0000_0024, 32'd0);
      chk("w3_we", {63'd0, ram_we1}, 64'd0);
      step();
      chk("b2b_fault2", {63'd0, flt1}, 64'd1);
      chk("b2b_faddr", {32'd0, faddr1}, 64'h24);
      set1(1'b0, 1'b0, 2'd2, 32'd0, 32'd0);
      step();

      // Timer interrupt: restart mtime from 0, compare at 10.
      set1(1'b0, 1'b1, 2'd2, TB + 32'h0, 32'd0);
      step();
      set1(1'b0, 1'b1, 2'd2, TB + 32'h8, 32'd10);
      step();
      set1(1'b0, 1'b1, 2'd2, TB + 32'hC, 32'd0);
      step();
      exp_t = 2;
      set1(1'b1, 1'b0, 2'd2, TB + 32'h0, 32'd0);
      chk("irq_mtime2", {32'd0, bus1.core_rdata}, 64'd2);
      chk("irq_low2", {63'd0, irq1}, 64'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         exp_t++;
         chk($sformatf("irq_mtime%0d", exp_t), {32'd0, bus1.core_rdata}, 64'(exp_t));
         chk($sformatf("irq_at%0d", exp_t), {63'd0, irq1}, (exp_t >= 10) ? 64'd1 : 64'd0);
      end
      set1(1'b0, 1'b1, 2'd2, TB + 32'hC, 32'd1);
      chk("irq_before_hi", {63'd0, irq1}, 64'd1);
      step();
      set1(1'b0, 1'b0, 2'd2, 32'd0, 32'd0);
      chk("irq_cmp_hi1", {63'd0, irq1}, 64'd0);

      // Sub-word timer write is rejected.
      set1(1'b0, 1'b1, 2'd1, TB + 32'h8, 32'd5);
      step();
      set1(1'b1, 1'b0, 2'd2, TB + 32'h8, 32'd0);
      chk("th_fault", {63'd0, flt1}, 64'd1);
      chk("th_faddr", {32'd0, faddr1}, 64'hFFFF_0008);
      chk("th_cmp_lo", {32'd0, bus1.core_rdata}, 64'd10);
      step();
      chk("th_fault_clr", {63'd0, flt1}, 64'd0);

      // Unmapped access.
      set1(1'b1, 1'b0, 2'd2, 32'h8000_0000, 32'd0);
      chk("um_rdata", {32'd0, bus1.core_rdata}, 64'd0);
      step();
      set1(1'b0, 1'b0, 2'd2, 32'd0, 32'd0);
      chk("um_fault", {63'd0, flt1}, 64'd1);
      chk("um_faddr", {32'd0, faddr1}, 64'h8000_0000);
      // Top RAM word is still a hit.
      set1(1'b0, 1'b1, 2'd2, 32'h0000_FFFC, 32'h1234_5678);
      chk("ram_top_we", {63'd0, ram_we1}, 64'd1);
      set1(1'b0, 1'b1, 2'd2, 32'h0001_0000, 32'h1234_5678);
      chk("ram_past_top_we", {63'd0, ram_we1}, 64'd0);
      set1(1'b0, 1'b0, 2'd2, 32'd0, 32'd0);

      // TICK_DIV=4: write mtime lo in the prescaler-wrap cycle.
      guard = 0;
      while ((cyc % 4) != 3 && guard < 8) begin
         step();
         guard++;
      end
      chk("wrap_wait", (guard < 8) ? 64'd1 : 64'd0, 64'd1);
      set4(1'b0, 1'b1, 2'd2, TB + 32'h0, 32'hFFFF_FFFF);
      step();
      set4(1'b1, 1'b0, 2'd2, TB + 32'h0, 32'd0);
      chk("t4_lo_wr", {32'd0, bus4.core_rdata}, 64'hFFFF_FFFF);
      set4(1'b1, 1'b0, 2'd2, TB + 32'h4, 32'd0);
      chk("t4_hi_wr", {32'd0, bus4.core_rdata}, 64'd0);
      repeat (3) step();
      set4(1'b1, 1'b0, 2'd2, TB + 32'h0, 32'd0);
      chk("t4_lo_3", {32'd0, bus4.core_rdata}, 64'hFFFF_FFFF);
      step();
      set4(1'b1, 1'b0, 2'd2, TB + 32'h0, 32'd0);
      chk("t4_lo_4", {32'd0, bus4.core_rdata}, 64'd0);
      set4(1'b1, 1'b0, 2'd2, TB + 32'h4, 32'd0);
      chk("t4_hi_4", {32'd0, bus4.core_rdata}, 64'd1);
      chk("t4_irq", {63'd0, irq4}, 64'd0);
      set4(1'b0, 1'b0, 2'd2, 32'd0, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
